// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM encoding
// and the bit-counter width helper.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    // Never returns 0 bits, so the counter stays legal for tiny widths.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// START/DONE handshake and operand/result bus of serial_subtractor.
// The OVF signal exists only when SERIAL_SUB_SIGNED_OVF_EN is defined.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] D;
    logic             BOUT;
    logic             Z;
    logic             BUSY;
    logic             DONE;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             OVF;

    modport master (
        output START, A, B,
        input  D, BOUT, Z, BUSY, DONE, OVF
    );

    modport slave (
        input  START, A, B,
        output D, BOUT, Z, BUSY, DONE, OVF
    );
`else
    modport master (
        output START, A, B,
        input  D, BOUT, Z, BUSY, DONE
    );

    modport slave (
        input  START, A, B,
        output D, BOUT, Z, BUSY, DONE
    );
`endif

endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor (a - b - bin) built from two half-subtractor stages
// whose borrows are ORed together.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    always_comb begin
        hs1_d = a ^ b;
        hs1_b = ~a & b;
        d     = hs1_d ^ bin;
        hs2_b = ~hs1_d & bin;
        bout  = hs1_b | hs2_b;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B, one bit per clock, LSB first.
// Defining SERIAL_SUB_SIGNED_OVF_EN adds the signed-overflow flag OVF.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                CLK,
    input  logic                RST,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_sh_nxt;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic             bit_d;
    logic             bit_bout;
    logic             accept;
    logic             last_bit;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor_bit u_bit (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        accept   = bus.START && ((state == IDLE) || (state == FIN));
        last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
        // New bit enters at the MSB; after WIDTH shifts bit i sits at index i.
        d_sh_nxt = WIDTH'({bit_d, d_sh} >> 1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.START) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = FIN;
            FIN:     state_nxt = bus.START ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY = (state == RUN);
        bus.DONE = (state == FIN);
    end

    // Visible results load together with the last bit so they are valid while DONE is high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_sh     <= '0;
            b_sh     <= '0;
            d_sh     <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            bus.D    <= '0;
            bus.BOUT <= 1'b0;
            bus.Z    <= 1'b1;
        end else if (accept) begin
            a_sh   <= bus.A;
            b_sh   <= bus.B;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            d_sh   <= d_sh_nxt;
            borrow <= bit_bout;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                bus.D    <= d_sh_nxt;
                bus.BOUT <= bit_bout;
                bus.Z    <= (d_sh_nxt == '0);
            end
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            bus.OVF <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.A[WIDTH-1];
            b_msb <= bus.B[WIDTH-1];
        end else if (last_bit) begin
            bus.OVF <= (a_msb != b_msb) && (bit_d != a_msb);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=32); OVF checks are built only
// when SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(32)) bus ();

    serial_subtractor #(.WIDTH(32)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch, confirm latency and busy window, check results at DONE, return to idle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] d_exp, input logic bout_exp,
                          input logic z_exp, input logic ovf_exp);
        bus.START = 1'b1;
        bus.A     = a;
        bus.B     = b;
        tick();
        check({tag, ".busy_rise"}, bus.BUSY, 1);
        bus.START = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        tick(31);
        check({tag, ".no_early_done"}, bus.DONE, 0);
        check({tag, ".busy_last_run"}, bus.BUSY, 1);
        tick();
        check({tag, ".done"}, bus.DONE, 1);
        check({tag, ".busy_fin"}, bus.BUSY, 0);
        check({tag, ".D"}, bus.D, d_exp);
        check({tag, ".BOUT"}, bus.BOUT, bout_exp);
        check({tag, ".Z"}, bus.Z, z_exp);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check({tag, ".OVF"}, bus.OVF, ovf_exp);
`else
        if (ovf_exp === 1'bx) checks += 0;
`endif
        tick();
        check({tag, ".done_pulse"}, bus.DONE, 0);
        check({tag, ".D_hold"}, bus.D, d_exp);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        tick(2);
        check("rst.D", bus.D, 0);
        check("rst.BOUT", bus.BOUT, 0);
        check("rst.Z", bus.Z, 1);
        check("rst.BUSY", bus.BUSY, 0);
        check("rst.DONE", bus.DONE, 0);
        rst_n = 1'b1;
        tick(2);

        run_op("sub5_3", 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0);
        run_op("sub3_5", 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        run_op("equal", 32'h1234_ABCD, 32'h1234_ABCD, 32'd0, 1'b0, 1'b1, 1'b0);

        // START while busy is ignored, then a back-to-back launch from FIN.
        bus.START = 1'b1;
        bus.A     = 32'd10;
        bus.B     = 32'd4;
        tick();
        bus.START = 1'b0;
        tick(9);
        bus.START = 1'b1;
        bus.A     = 32'd1;
        bus.B     = 32'd1;
        tick();
        check("busy_start.BUSY", bus.BUSY, 1);
        bus.START = 1'b0;
        tick(22);
        check("busy_start.DONE", bus.DONE, 1);
        check("busy_start.D", bus.D, 32'd6);
        check("busy_start.Z", bus.Z, 0);
        bus.START = 1'b1;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        tick();
        check("b2b.BUSY", bus.BUSY, 1);
        check("b2b.DONE_low", bus.DONE, 0);
        bus.START = 1'b0;
        tick(16);
        check("b2b.D_mid_hold", bus.D, 32'd6);
        check("b2b.Z_mid_hold", bus.Z, 0);
        tick(16);
        check("b2b.DONE", bus.DONE, 1);
        check("b2b.D", bus.D, 32'd0);
        check("b2b.Z", bus.Z, 1);
        tick();

        run_op("wrap0_1", 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("min_neg", 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        run_op("sub2_1", 32'd2, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        run_op("neg_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

        // Reset mid-operation discards the partial result.
        bus.START = 1'b1;
        bus.A     = 32'd100;
        bus.B     = 32'd1;
        tick();
        bus.START = 1'b0;
        tick(14);
        check("mid.BUSY_before", bus.BUSY, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst.BUSY", bus.BUSY, 0);
        check("mid_rst.DONE", bus.DONE, 0);
        check("mid_rst.D", bus.D, 0);
        check("mid_rst.Z", bus.Z, 1);
        check("mid_rst.BOUT", bus.BOUT, 0);
        tick();
        rst_n = 1'b1;
        tick(40);
        check("post_rst.DONE", bus.DONE, 0);
        check("post_rst.BUSY", bus.BUSY, 0);
        run_op("after_rst", 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
